flag_context_unit: RTL and testbench

Parametrised successor to the processor's flag register / branch-condition pair. Holds NZCV and mode flags for CONTEXTS hardware contexts, with context 0 reserved as BIOS. Performs save/restore of flags on context switch, evaluates 5-bit condition codes against live flags, and runs the I/O wait handshake (confirmation / continue button) that stalls the datapath. Sits inside the control unit between the instruction decoder, the control core and the ALU/barrel shifter flag outputs.

---
 rtl/flag_context_unit_pkg.sv | 49 ++++
 rtl/flag_condition_eval.sv | 37 +++
 rtl/flag_context_unit.sv | 165 ++++++++++++++++
 tb/tb_flag_context_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_context_unit_pkg.sv
// Shared definitions for the flag/context unit: update modes, condition codes,
// FSM encoding and the flag record stored per context.
package flag_context_unit_pkg;

  localparam int BIOS_CTX = 0;

  localparam logic [3:0] UPD_HOLD        = 4'd0;
  localparam logic [3:0] UPD_ALU_NZCV    = 4'd1;
  localparam logic [3:0] UPD_ALU_NZ      = 4'd2;
  localparam logic [3:0] UPD_BS_NZC      = 4'd3;
  localparam logic [3:0] UPD_ALU_NZ_BS_C = 4'd4;
  localparam logic [3:0] UPD_SET_MODE    = 4'd5;
  localparam logic [3:0] UPD_CLR_MODE    = 4'd6;

  localparam logic [4:0] CC_EQ = 5'd0;
  localparam logic [4:0] CC_NE = 5'd1;
  localparam logic [4:0] CC_CS = 5'd2;
  localparam logic [4:0] CC_CC = 5'd3;
  localparam logic [4:0] CC_MI = 5'd4;
  localparam logic [4:0] CC_PL = 5'd5;
  localparam logic [4:0] CC_VS = 5'd6;
  localparam logic [4:0] CC_VC = 5'd7;
  localparam logic [4:0] CC_HI = 5'd8;
  localparam logic [4:0] CC_LS = 5'd9;
  localparam logic [4:0] CC_GE = 5'd10;
  localparam logic [4:0] CC_LT = 5'd11;
  localparam logic [4:0] CC_GT = 5'd12;
  localparam logic [4:0] CC_LE = 5'd13;
  localparam logic [4:0] CC_AL = 5'd14;
  localparam logic [4:0] CC_NV = 5'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_LOAD,
    ST_ACK,
    ST_IO_WAIT,
    ST_IO_DONE
  } fsm_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
    logic m;
  } flags_t;

endpackage

// File: rtl/flag_condition_eval.sv
// Combinational ARM-style condition evaluation; codes above AL never pass.
module flag_condition_eval
  import flag_context_unit_pkg::*;
#(
  parameter int CONDITION_WIDTH = 5
) (
  input  logic                       n,
  input  logic                       z,
  input  logic                       c,
  input  logic                       v,
  input  logic [CONDITION_WIDTH-1:0] condition_code,
  output logic                       take
);

  always_comb begin
    take = 1'b0;
    case (condition_code)
      CONDITION_WIDTH'(CC_EQ): take = z;
      CONDITION_WIDTH'(CC_NE): take = ~z;
      CONDITION_WIDTH'(CC_CS): take = c;
      CONDITION_WIDTH'(CC_CC): take = ~c;
      CONDITION_WIDTH'(CC_MI): take = n;
      CONDITION_WIDTH'(CC_PL): take = ~n;
      CONDITION_WIDTH'(CC_VS): take = v;
      CONDITION_WIDTH'(CC_VC): take = ~v;
      CONDITION_WIDTH'(CC_HI): take = c & ~z;
      CONDITION_WIDTH'(CC_LS): take = ~c | z;
      CONDITION_WIDTH'(CC_GE): take = (n == v);
      CONDITION_WIDTH'(CC_LT): take = (n != v);
      CONDITION_WIDTH'(CC_GT): take = ~z & (n == v);
      CONDITION_WIDTH'(CC_LE): take = z | (n != v);
      CONDITION_WIDTH'(CC_AL): take = 1'b1;
      default:                 take = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_context_unit.sv
// Live NZCV/mode flags with per-context save/restore, condition evaluation and
// the I/O wait handshake that stalls the datapath.
module flag_context_unit
  import flag_context_unit_pkg::*;
#(
  parameter int CONTEXTS          = 4,
  parameter int CTX_WIDTH         = 2,
  parameter int CONDITION_WIDTH   = 5,
  parameter int UPDATE_MODE_WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [UPDATE_MODE_WIDTH-1:0] update_mode,
  input  logic                         alu_negative,
  input  logic                         alu_zero,
  input  logic                         alu_carry,
  input  logic                         alu_overflow,
  input  logic                         bs_negative,
  input  logic                         bs_zero,
  input  logic                         bs_carry,
  input  logic [CONDITION_WIDTH-1:0]   condition_code,
  input  logic                         switch_req,
  input  logic [CTX_WIDTH-1:0]         target_context,
  input  logic                         io_req,
  input  logic                         io_is_input,
  input  logic                         confirmation,
  input  logic                         continue_button,
  output logic                         negative_flag,
  output logic                         zero_flag,
  output logic                         carry_flag,
  output logic                         overflow_flag,
  output logic                         mode_flag,
  output logic [CTX_WIDTH-1:0]         current_context,
  output logic                         is_bios,
  output logic                         should_take_branch,
  output logic                         stall,
  output logic                         switch_ack,
  output logic                         io_done
);

  fsm_state_e                   state_q, state_d;
  flags_t                       flags_q, flags_d;
  flags_t [CONTEXTS-1:0]        bank_q, bank_d;
  logic [CTX_WIDTH-1:0]         ctx_q, ctx_d;
  logic [CTX_WIDTH-1:0]         target_q, target_d;
  logic                         io_in_q, io_in_d;
  logic                         conf_prev_q, conf_prev_d;
  logic                         cont_prev_q, cont_prev_d;
  logic                         io_edge;

  // Edge detect against last cycle's level, so a level already high on entry never fires.
  assign io_edge = io_in_q ? (confirmation & ~conf_prev_q)
                           : (continue_button & ~cont_prev_q);

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    bank_d      = bank_q;
    ctx_d       = ctx_q;
    target_d    = target_q;
    io_in_d     = io_in_q;
    conf_prev_d = confirmation;
    cont_prev_d = continue_button;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          case (update_mode)
            UPDATE_MODE_WIDTH'(UPD_ALU_NZCV): begin
              flags_d.n = alu_negative;
              flags_d.z = alu_zero;
              flags_d.c = alu_carry;
              flags_d.v = alu_overflow;
            end
            UPDATE_MODE_WIDTH'(UPD_ALU_NZ): begin
              flags_d.n = alu_negative;
              flags_d.z = alu_zero;
            end
            UPDATE_MODE_WIDTH'(UPD_BS_NZC): begin
              flags_d.n = bs_negative;
              flags_d.z = bs_zero;
              flags_d.c = bs_carry;
            end
            UPDATE_MODE_WIDTH'(UPD_ALU_NZ_BS_C): begin
              flags_d.n = alu_negative;
              flags_d.z = alu_zero;
              flags_d.c = bs_carry;
            end
            UPDATE_MODE_WIDTH'(UPD_SET_MODE): flags_d.m = 1'b1;
            UPDATE_MODE_WIDTH'(UPD_CLR_MODE): flags_d.m = 1'b0;
            default: ;
          endcase
        end
        if (switch_req) begin
          state_d  = ST_SAVE;
          target_d = target_context;
        end else if (io_req) begin
          state_d = ST_IO_WAIT;
          io_in_d = io_is_input;
        end
      end
      ST_SAVE: begin
        bank_d[ctx_q] = flags_q;
        state_d       = ST_LOAD;
      end
      ST_LOAD: begin
        flags_d = bank_q[target_q];
        if (target_q == CTX_WIDTH'(BIOS_CTX)) flags_d.m = 1'b0;
        ctx_d   = target_q;
        state_d = ST_ACK;
      end
      ST_ACK:     state_d = ST_IDLE;
      ST_IO_WAIT: if (io_edge) state_d = ST_IO_DONE;
      ST_IO_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      bank_q      <= '0;
      ctx_q       <= '0;
      target_q    <= '0;
      io_in_q     <= 1'b0;
      conf_prev_q <= 1'b0;
      cont_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      bank_q      <= bank_d;
      ctx_q       <= ctx_d;
      target_q    <= target_d;
      io_in_q     <= io_in_d;
      conf_prev_q <= conf_prev_d;
      cont_prev_q <= cont_prev_d;
    end
  end

  assign negative_flag   = flags_q.n;
  assign zero_flag       = flags_q.z;
  assign carry_flag      = flags_q.c;
  assign overflow_flag   = flags_q.v;
  assign mode_flag       = flags_q.m;
  assign current_context = ctx_q;
  assign is_bios         = (ctx_q == CTX_WIDTH'(BIOS_CTX));
  assign stall           = (state_q == ST_SAVE) || (state_q == ST_LOAD) ||
                           (state_q == ST_IO_WAIT);
  assign switch_ack      = (state_q == ST_ACK);
  assign io_done         = (state_q == ST_IO_DONE);

  flag_condition_eval #(
    .CONDITION_WIDTH(CONDITION_WIDTH)
  ) u_cond (
    .n              (flags_q.n),
    .z              (flags_q.z),
    .c              (flags_q.c),
    .v              (flags_q.v),
    .condition_code (condition_code),
    .take           (should_take_branch)
  );

endmodule

// File: tb/tb_flag_context_unit.sv
// Directed bench for flag_context_unit; status word packs
// {N,Z,C,V,M, ctx[1:0], is_bios, stall, switch_ack, io_done}.
module tb_flag_context_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] update_mode = '0;
  logic       alu_negative = 0, alu_zero = 0, alu_carry = 0, alu_overflow = 0;
  logic       bs_negative = 0, bs_zero = 0, bs_carry = 0;
  logic [4:0] condition_code = '0;
  logic       switch_req = 0;
  logic [1:0] target_context = '0;
  logic       io_req = 0, io_is_input = 0, confirmation = 0, continue_button = 0;
  logic       negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag;
  logic [1:0] current_context;
  logic       is_bios, should_take_branch, stall, switch_ack, io_done;

  int checks = 0;
  int errors = 0;
  logic [10:0] st, exp_st;

  assign st = {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag,
               current_context, is_bios, stall, switch_ack, io_done};

  always #5 clock = ~clock;

  flag_context_unit dut (
    .clock(clock), .reset(reset), .enable(enable), .update_mode(update_mode),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .bs_negative(bs_negative), .bs_zero(bs_zero),
    .bs_carry(bs_carry), .condition_code(condition_code), .switch_req(switch_req),
    .target_context(target_context), .io_req(io_req), .io_is_input(io_is_input),
    .confirmation(confirmation), .continue_button(continue_button),
    .negative_flag(negative_flag), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .mode_flag(mode_flag),
    .current_context(current_context), .is_bios(is_bios),
    .should_take_branch(should_take_branch), .stall(stall),
    .switch_ack(switch_ack), .io_done(io_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
    alu_negative = n; alu_zero = z; alu_carry = c; alu_overflow = v;
  endtask

  task automatic test_reset();
    tick(); tick();
    exp_st = 11'b00000_00_1_000;
    checks++;
    if (st !== exp_st) begin
      $display("FAIL reset_state got=%b exp=%b", st, exp_st); errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_update_and_cond();
    logic [4:0] codes [9];
    logic       takes [9];
    update_mode = 4'd1; set_alu(1, 0, 1, 1); enable = 1; tick();
    exp_st = 11'b10110_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL upd_alu_nzcv got=%b exp=%b", st, exp_st); errors++; end
    condition_code = 5'd10; #1;
    checks++;
    if (should_take_branch !== 1'b1) begin $display("FAIL cond_ge got=%b exp=1", should_take_branch); errors++; end
    condition_code = 5'd11; #1;
    checks++;
    if (should_take_branch !== 1'b0) begin $display("FAIL cond_lt got=%b exp=0", should_take_branch); errors++; end

    update_mode = 4'd4; set_alu(0, 1, 0, 0); bs_negative = 1; bs_zero = 0; bs_carry = 0; tick();
    exp_st = 11'b01010_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL upd_alu_nz_bs_c got=%b exp=%b", st, exp_st); errors++; end

    update_mode = 4'd3; bs_negative = 1; bs_zero = 0; bs_carry = 1; tick();
    exp_st = 11'b10110_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL upd_bs_nzc got=%b exp=%b", st, exp_st); errors++; end

    update_mode = 4'd2; set_alu(0, 1, 0, 0); tick();
    exp_st = 11'b01110_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL upd_alu_nz got=%b exp=%b", st, exp_st); errors++; end

    // Flags now N0 Z1 C1 V1
    codes = '{5'd0, 5'd1, 5'd3, 5'd8, 5'd9, 5'd12, 5'd14, 5'd15, 5'd20};
    takes = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      condition_code = codes[i]; #1;
      checks++;
      if (should_take_branch !== takes[i]) begin
        $display("FAIL cond_code_%0d got=%b exp=%b", codes[i], should_take_branch, takes[i]); errors++;
      end
    end

    update_mode = 4'd5; tick();
    update_mode = 4'd7; set_alu(1, 0, 0, 0); tick();
    enable = 0; update_mode = 4'd1; tick();
    exp_st = 11'b01111_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL upd_mode_hold got=%b exp=%b", st, exp_st); errors++; end
  endtask

  task automatic test_switch();
    switch_req = 1; target_context = 2'd2; tick();
    exp_st = 11'b01111_00_1_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_save got=%b exp=%b", st, exp_st); errors++; end
    switch_req = 0; enable = 1; update_mode = 4'd1; set_alu(1, 0, 1, 1); tick();
    exp_st = 11'b01111_00_1_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_load got=%b exp=%b", st, exp_st); errors++; end
    tick();
    exp_st = 11'b00000_10_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_ack_ctx2 got=%b exp=%b", st, exp_st); errors++; end
    enable = 0; tick();
    exp_st = 11'b00000_10_0_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_idle_ctx2 got=%b exp=%b", st, exp_st); errors++; end

    enable = 1; update_mode = 4'd1; set_alu(1, 1, 0, 0); tick();
    update_mode = 4'd5; tick(); enable = 0;
    exp_st = 11'b11001_10_0_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL ctx2_flags got=%b exp=%b", st, exp_st); errors++; end

    // Return to BIOS with a flag update attempted during LOAD
    switch_req = 1; target_context = 2'd0; tick();
    switch_req = 0; enable = 1; update_mode = 4'd1; set_alu(1, 0, 1, 1); tick();
    exp_st = 11'b11001_10_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw0_load got=%b exp=%b", st, exp_st); errors++; end
    tick();
    exp_st = 11'b01110_00_1_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw0_restore got=%b exp=%b", st, exp_st); errors++; end
    enable = 0; tick();

    switch_req = 1; target_context = 2'd2; tick();
    switch_req = 0; tick(); tick();
    exp_st = 11'b11001_10_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw2_restore got=%b exp=%b", st, exp_st); errors++; end
    tick();

    // Same-context switch still runs the full sequence
    switch_req = 1; tick();
    exp_st = 11'b11001_10_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_same_save got=%b exp=%b", st, exp_st); errors++; end
    switch_req = 0; tick(); tick();
    exp_st = 11'b11001_10_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_same_ack got=%b exp=%b", st, exp_st); errors++; end
    tick();
  endtask

  task automatic test_io();
    confirmation = 1; io_req = 1; io_is_input = 1; tick();
    io_req = 0; tick(); tick();
    exp_st = 11'b11001_10_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL io_level_held got=%b exp=%b", st, exp_st); errors++; end
    confirmation = 0; tick();
    checks++;
    if (st !== exp_st) begin $display("FAIL io_conf_low got=%b exp=%b", st, exp_st); errors++; end
    confirmation = 1; tick();
    exp_st = 11'b11001_10_0_001;
    checks++;
    if (st !== exp_st) begin $display("FAIL io_in_done got=%b exp=%b", st, exp_st); errors++; end
    confirmation = 0; tick();
    exp_st = 11'b11001_10_0_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL io_in_idle got=%b exp=%b", st, exp_st); errors++; end

    // Output wait: direction latched at entry; confirmation edges ignored
    io_req = 1; io_is_input = 0; tick();
    io_req = 0; io_is_input = 1; enable = 1; update_mode = 4'd1; set_alu(0, 0, 0, 0);
    confirmation = 1; tick();
    exp_st = 11'b11001_10_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL io_out_conf_ignored got=%b exp=%b", st, exp_st); errors++; end
    confirmation = 0; continue_button = 1; tick();
    exp_st = 11'b11001_10_0_001;
    checks++;
    if (st !== exp_st) begin $display("FAIL io_out_done got=%b exp=%b", st, exp_st); errors++; end
    enable = 0; continue_button = 0; tick();
  endtask

  task automatic test_back_to_back();
    switch_req = 1; target_context = 2'd1; io_req = 1; io_is_input = 0; tick();
    exp_st = 11'b11001_10_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL both_save_first got=%b exp=%b", st, exp_st); errors++; end
    switch_req = 0; tick(); tick();
    exp_st = 11'b00000_01_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL both_ack got=%b exp=%b", st, exp_st); errors++; end
    tick(); tick();
    exp_st = 11'b00000_01_0_100;
    checks++;
    if (st !== exp_st) begin $display("FAIL both_io_wait got=%b exp=%b", st, exp_st); errors++; end
    io_req = 0; switch_req = 1; target_context = 2'd3; tick();
    checks++;
    if (st !== exp_st) begin $display("FAIL sw_ignored_in_io got=%b exp=%b", st, exp_st); errors++; end
    continue_button = 1; tick();
    exp_st = 11'b00000_01_0_001;
    checks++;
    if (st !== exp_st) begin $display("FAIL both_io_done got=%b exp=%b", st, exp_st); errors++; end
    continue_button = 0; tick(); tick();
    switch_req = 0; tick(); tick();
    exp_st = 11'b00000_11_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL held_sw_ack got=%b exp=%b", st, exp_st); errors++; end
    tick();
  endtask

  task automatic test_reset_mid_switch();
    enable = 1; update_mode = 4'd1; set_alu(1, 1, 1, 1); tick(); enable = 0;
    exp_st = 11'b11110_11_0_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL ctx3_flags got=%b exp=%b", st, exp_st); errors++; end
    switch_req = 1; target_context = 2'd0; tick();
    switch_req = 0;
    #1 reset = 1;
    #1;
    exp_st = 11'b00000_00_1_000;
    checks++;
    if (st !== exp_st) begin $display("FAIL async_reset got=%b exp=%b", st, exp_st); errors++; end
    tick();
    reset = 0;
    switch_req = 1; target_context = 2'd3; tick();
    switch_req = 0; tick(); tick();
    exp_st = 11'b00000_11_0_010;
    checks++;
    if (st !== exp_st) begin $display("FAIL bank_lost_on_reset got=%b exp=%b", st, exp_st); errors++; end
    tick();
  endtask

  initial begin
    test_reset();
    test_update_and_cond();
    test_switch();
    test_io();
    test_back_to_back();
    test_reset_mid_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
